// File: rtl/perf_cnt_sched.sv
// Purpose: shares one single-ported 8x32 counter bank between 8 event sources and a host read/clear port.
// Latency: event pulse -> bank_inc earliest next cycle; host request -> rsp_valid/rsp_data next cycle.
// Backpressure: host always wins and is accepted the cycle it is valid; events queue in saturating pend counters.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   ev[7:0]            event pulses, one occurrence per set bit per cycle
//   req_valid/ready    host request handshake; req_idx selects counter, req_clr = read-and-clear
//   rsp_valid/data     one-cycle response carrying the pre-clear counter value
//   bank_idx/inc/clr   single bank operation for this edge (combinational)
//   bank_data          combinational read of bank[bank_idx]
//   overflow[7:0]      sticky lost-event flags
//
// Build option: define PERF_SCHED_OVF_EN to implement the overflow flags; otherwise overflow reads 8'h00
// and events lost to pend saturation are dropped silently.

module perf_cnt_sched #(
    parameter int PEND_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ev,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_idx,
    input  logic        req_clr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [2:0]  bank_idx,
    output logic        bank_inc,
    output logic        bank_clr,
    input  logic [31:0] bank_data,
    output logic [7:0]  overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    logic [PEND_W-1:0] pend [8];
    logic [2:0]        rr_ptr;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;

    logic              host_gnt;
    logic              evt_gnt;
    logic              evt_hit;
    logic [2:0]        evt_idx;
    logic [2:0]        cand;
    logic [7:0]        served;

    // Round-robin search: first nonzero pend starting at rr_ptr, wrapping 7->0.
    // The 3-bit add wraps naturally.
    always_comb begin
        evt_hit = 1'b0;
        evt_idx = 3'd0;
        cand    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = rr_ptr + 3'(k);
            if (!evt_hit && (pend[cand] != PEND_ZERO)) begin
                evt_hit = 1'b1;
                evt_idx = cand;
            end
        end
    end

    // Host has absolute priority; nothing is granted while in reset.
    assign host_gnt = req_valid & ~rst;
    assign evt_gnt  = ~rst & ~req_valid & evt_hit;

    assign req_ready = host_gnt;
    assign bank_inc  = evt_gnt;
    assign bank_clr  = host_gnt & req_clr;

    always_comb begin
        bank_idx = 3'd0;
        if (req_valid) begin
            bank_idx = req_idx;
        end else if (evt_hit) begin
            bank_idx = evt_idx;
        end
    end

    always_comb begin
        served = 8'h00;
        if (evt_gnt) begin
            served[evt_idx] = 1'b1;
        end
    end

    // Pending counters: +ev, -served. Served and event together cancel out.
    // At max, an unserved event is lost and the count holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                pend[i] <= PEND_ZERO;
            end
            rr_ptr      <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (ev[i] && !served[i]) begin
                    if (pend[i] != PEND_MAX) begin
                        pend[i] <= pend[i] + PEND_ONE;
                    end
                end else if (!ev[i] && served[i]) begin
                    pend[i] <= pend[i] - PEND_ONE;
                end
            end
            if (evt_gnt) begin
                rr_ptr <= evt_idx + 3'd1;
            end
            rsp_valid_q <= host_gnt;
            if (host_gnt) begin
                // Sampled before the bank applies any clear at this edge.
                rsp_data_q <= bank_data;
            end
        end
    end

    // A response in flight when reset arrives is suppressed immediately.
    assign rsp_valid = rsp_valid_q & ~rst;
    assign rsp_data  = rsp_data_q;

`ifdef PERF_SCHED_OVF_EN
    logic [7:0] lost;
    logic [7:0] ovf_clr;
    logic [7:0] ovf_q;

    always_comb begin
        lost = 8'h00;
        for (int i = 0; i < 8; i++) begin
            lost[i] = ev[i] & ~served[i] & (pend[i] == PEND_MAX);
        end
    end

    assign ovf_clr = bank_clr ? (8'h01 << req_idx) : 8'h00;

    // A loss in the same cycle as a clear of that index still sets the flag:
    // the event really was dropped after the clear point.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 8'h00;
        end else begin
            ovf_q <= (ovf_q & ~ovf_clr) | lost;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 8'h00;
`endif

endmodule

// File: tb/tb_perf_cnt_sched.sv
module tb_perf_cnt_sched;

    localparam int PMAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ev;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_idx;
    logic        req_clr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [2:0]  bank_idx;
    logic        bank_inc;
    logic        bank_clr;
    logic [31:0] bank_data;
    logic [7:0]  overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    perf_cnt_sched #(.PEND_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ev        (ev),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_clr   (req_clr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .bank_idx  (bank_idx),
        .bank_inc  (bank_inc),
        .bank_clr  (bank_clr),
        .bank_data (bank_data),
        .overflow  (overflow)
    );

    // Counter bank owned by the bench
    logic [31:0] bank [8];
    logic        wipe;
    logic        pl_vld;
    logic [2:0]  pl_idx;
    logic [31:0] pl_val;

    assign bank_data = bank[bank_idx];

    always @(posedge clk) begin
        if (wipe) begin
            for (int k = 0; k < 8; k++) bank[k] <= 32'h0;
        end else if (pl_vld) begin
            bank[pl_idx] <= pl_val;
        end else if (bank_inc) begin
            bank[bank_idx] <= bank[bank_idx] + 32'd1;
        end else if (bank_clr) begin
            bank[bank_idx] <= 32'h0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending event counts, rotating priority pointer,
    // last response and lost-event flags.
    int          m_pend [8];
    int          m_rr   = 0;
    bit          m_rv   = 0;
    logic [31:0] m_rd   = 32'h0;
    logic [7:0]  m_ovf  = 8'h00;
    bit          chk_en = 0;

    initial for (int k = 0; k < 8; k++) m_pend[k] = 0;

    // Index of the event source that should be served next, -1 if none pending.
    function automatic int pick();
        for (int k = 0; k < 8; k++) begin
            if (m_pend[(m_rr + k) % 8] > 0) return (m_rr + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        int p;
        if (rst) begin
            for (int k = 0; k < 8; k++) m_pend[k] = 0;
            m_rr  = 0;
            m_rv  = 0;
            m_rd  = 32'h0;
            m_ovf = 8'h00;
        end else begin
            w = req_valid ? -1 : pick();
            m_rv = req_valid;
            if (req_valid) begin
                m_rd = bank[req_idx];
`ifdef PERF_SCHED_OVF_EN
                if (req_clr) m_ovf[req_idx] = 1'b0;
`endif
            end
            for (int k = 0; k < 8; k++) begin
                p = m_pend[k] + int'(ev[k]) - ((w == k) ? 1 : 0);
                if (p > PMAX) begin
                    p = PMAX;
`ifdef PERF_SCHED_OVF_EN
                    m_ovf[k] = 1'b1;
`endif
                end
                m_pend[k] = p;
            end
            if (w >= 0) m_rr = (w + 1) % 8;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int w;
        bit e_host;
        bit e_inc;
        if (chk_en) begin
            w      = pick();
            e_host = !rst && req_valid;
            e_inc  = !rst && !req_valid && (w >= 0);
            chk("req_ready", {31'h0, req_ready}, {31'h0, e_host});
            chk("bank_inc",  {31'h0, bank_inc},  {31'h0, e_inc});
            chk("bank_clr",  {31'h0, bank_clr},  {31'h0, e_host && req_clr});
            if (e_host) chk("bank_idx_host", {29'h0, bank_idx}, {29'h0, req_idx});
            if (e_inc)  chk("bank_idx_evt",  {29'h0, bank_idx}, 32'(w));
            chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rv && !rst});
            chk("rsp_data",  rsp_data, m_rd);
            chk("overflow",  {24'h0, overflow}, {24'h0, m_ovf});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ev = 8'h00; req_valid = 1'b0; req_clr = 1'b0; req_idx = 3'd0;
        wipe = 1'b1;
        cyc();
        wipe = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ev = 8'h00; req_valid = 1'b0; req_idx = 3'd0; req_clr = 1'b0;
        wipe = 1'b1; pl_vld = 1'b0; pl_idx = 3'd0; pl_val = 32'h0;
        cyc();
        chk_en = 1;
        wipe   = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // Single event on source 0
        ev = 8'h01;
        cyc();
        ev = 8'h00;
        at_neg();
        chk("t1_inc", {31'h0, bank_inc}, 32'h1);
        chk("t1_idx", {29'h0, bank_idx}, 32'h0);
        cyc();
        at_neg();
        chk("t1_inc_after", {31'h0, bank_inc}, 32'h0);
        chk("t1_bank0", bank[0], 32'h1);

        // All sources at once: served in index order
        do_reset();
        ev = 8'hFF;
        cyc();
        ev = 8'h00;
        for (int k = 0; k < 8; k++) begin
            at_neg();
            chk("t2_inc", {31'h0, bank_inc}, 32'h1);
            chk("t2_idx", {29'h0, bank_idx}, 32'(k));
            cyc();
        end
        at_neg();
        chk("t2_idle", {31'h0, bank_inc}, 32'h0);
        for (int k = 0; k < 8; k++) chk("t2_bank", bank[k], 32'h1);

        // Host holds the bank while source 3 fires 20 times
        do_reset();
        req_valid = 1'b1; req_idx = 3'd5; req_clr = 1'b0; ev = 8'h08;
        repeat (20) cyc();
        req_valid = 1'b0; ev = 8'h00;
        at_neg();
`ifdef PERF_SCHED_OVF_EN
        chk("t3_ovf", {24'h0, overflow}, 32'h08);
`else
        chk("t3_ovf", {24'h0, overflow}, 32'h00);
`endif
        chk("t3_first_inc", {31'h0, bank_inc}, 32'h1);
        repeat (20) cyc();
        at_neg();
        chk("t3_bank3", bank[3], 32'd15);
        chk("t3_idle", {31'h0, bank_inc}, 32'h0);

        // Read-and-clear with an event pending for the same counter
        pl_vld = 1'b1; pl_idx = 3'd2; pl_val = 32'h42;
        cyc();
        pl_vld = 1'b0;
        ev = 8'h04; req_valid = 1'b1; req_idx = 3'd2; req_clr = 1'b1;
        cyc();
        ev = 8'h00; req_valid = 1'b0; req_clr = 1'b0;
        at_neg();
        chk("t4_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("t4_rsp_data", rsp_data, 32'h42);
        chk("t4_bank2_clr", bank[2], 32'h0);
        chk("t4_inc", {31'h0, bank_inc}, 32'h1);
        chk("t4_idx", {29'h0, bank_idx}, 32'h2);
        cyc();
        at_neg();
        chk("t4_bank2", bank[2], 32'h1);
        chk("t4_rsp_gone", {31'h0, rsp_valid}, 32'h0);

        // Continuous event on source 6
        do_reset();
        ev = 8'h40;
        cyc();
        for (int k = 0; k < 10; k++) begin
            at_neg();
            chk("t5_inc", {31'h0, bank_inc}, 32'h1);
            chk("t5_idx", {29'h0, bank_idx}, 32'h6);
            cyc();
        end
        ev = 8'h00;
        at_neg();
        chk("t5_ovf", {24'h0, overflow}, 32'h0);
        cyc();
        at_neg();
        chk("t5_bank6", bank[6], 32'd11);

        // Reset with work pending and a response in flight
        ev = 8'hFF;
        cyc();
        ev = 8'h00; req_valid = 1'b1; req_idx = 3'd1; req_clr = 1'b0;
        cyc();
        req_valid = 1'b0; rst = 1'b1;
        at_neg();
        chk("t6_rsp_dropped", {31'h0, rsp_valid}, 32'h0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            chk("t6_no_inc", {31'h0, bank_inc}, 32'h0);
            cyc();
        end
        at_neg();
        chk("t6_ovf", {24'h0, overflow}, 32'h0);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
